// File: rtl/lc2k_instr_encoder.sv
// Packs decoded LC2K instruction fields into 32-bit machine words and streams them
// into instruction memory from a start address until HALT, memory full or a bad offset.
module lc2k_instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [2:0]        in_reg_a,
  input  logic [2:0]        in_reg_b,
  input  logic [2:0]        in_dest,
  input  logic [31:0]       in_offset,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_full,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JALR = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   wptr_q;
  logic                last_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                done_q;
  logic                err_range_q;
  logic                err_full_q;
  logic [ADDR_W:0]     word_count_q;

  logic                range_bad_d;
  logic [31:0]         wdata_d;

  function automatic logic uses_offset(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // Offset fits in 16-bit two's complement when bits 31:15 are a pure sign extension.
  function automatic logic offset_fits16(input logic [31:0] off);
    return (&off[31:15]) | ~(|off[31:15]);
  endfunction

  function automatic logic [31:0] encode_word(
    input logic [2:0]  op,
    input logic [2:0]  reg_a,
    input logic [2:0]  reg_b,
    input logic [2:0]  dest,
    input logic [31:0] off
  );
    logic [31:0] w;
    w        = '0;
    w[24:22] = op;
    case (op)
      OP_ADD, OP_NOR: begin
        w[21:19] = reg_a;
        w[18:16] = reg_b;
        w[2:0]   = dest;
      end
      OP_LW, OP_SW, OP_BEQ: begin
        w[21:19] = reg_a;
        w[18:16] = reg_b;
        w[15:0]  = off[15:0];
      end
      OP_JALR: begin
        w[21:19] = reg_a;
        w[18:16] = reg_b;
      end
      default: ;
    endcase
    return w;
  endfunction

  always_comb begin
    range_bad_d = uses_offset(in_opcode) && !offset_fits16(in_offset);
    wdata_d     = encode_word(in_opcode, in_reg_a, in_reg_b, in_dest, in_offset);
  end

  // last_q marks that the top address has been written; addresses never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      last_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      err_range_q  <= 1'b0;
      err_full_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_RUN;
            wptr_q       <= base_addr;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            err_range_q  <= 1'b0;
            err_full_q   <= 1'b0;
            word_count_q <= '0;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            if (range_bad_d) begin
              err_range_q <= 1'b1;
              state_q     <= S_ERR;
            end else if (last_q) begin
              err_full_q <= 1'b1;
              state_q    <= S_ERR;
            end else begin
              mem_we_q     <= 1'b1;
              mem_addr_q   <= wptr_q;
              mem_wdata_q  <= wdata_d;
              wptr_q       <= wptr_q + 1'b1;
              last_q       <= (wptr_q == '1);
              word_count_q <= word_count_q + 1'b1;
              if (in_opcode == OP_HALT) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign err_range  = err_range_q;
  assign err_full   = err_full_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_lc2k_instr_encoder.sv
// Randomized scoreboard bench for lc2k_instr_encoder, with a small-memory instance for the full case.
module tb_lc2k_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode, in_reg_a, in_reg_b, in_dest;
  logic [31:0] in_offset;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, err_range, err_full;
  logic [8:0]  word_count;

  logic        s_start;
  logic [1:0]  s_base;
  logic        s_valid, s_ready;
  logic [2:0]  s_op;
  logic        s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_busy, s_done, s_erange, s_efull;
  logic [2:0]  s_count;

  always #5 clk = ~clk;

  lc2k_instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_dest(in_dest), .in_offset(in_offset),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err_range(err_range), .err_full(err_full), .word_count(word_count)
  );

  lc2k_instr_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .base_addr(s_base),
    .in_valid(s_valid), .in_ready(s_ready), .in_opcode(s_op),
    .in_reg_a(3'd5), .in_reg_b(3'd6), .in_dest(3'd7), .in_offset(32'h1234),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata), .busy(s_busy),
    .done(s_done), .err_range(s_erange), .err_full(s_efull), .word_count(s_count)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: program state in plain integers, next address allowed to run past the top.
  typedef enum {M_IDLE, M_RUN, M_DONE, M_ERR} mstate_e;
  typedef struct { int addr; longint word; int cnt; } exp_t;

  mstate_e m_state = M_IDLE;
  int      m_next  = 0;
  int      m_cnt   = 0;
  bit      m_done = 0, m_erange = 0, m_efull = 0;
  exp_t    sb[$];
  bit      mon_en = 0;

  function automatic longint model_word(int op, int a, int b, int d, int off);
    longint w;
    w = op * (2 ** 22);
    if (op == 0 || op == 1) w += a * (2 ** 19) + b * (2 ** 16) + d;
    else if (op >= 2 && op <= 4) w += a * (2 ** 19) + b * (2 ** 16) + (off & 32'hFFFF);
    else if (op == 5) w += a * (2 ** 19) + b * (2 ** 16);
    return w;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_next = 0; m_cnt = 0;
    m_done = 0; m_erange = 0; m_efull = 0;
    sb.delete();
  endtask

  // Called at posedge+1: drive one cycle, let the edge happen, then advance the model.
  task automatic cycle(input bit st, input int ba, input bit v, input int op,
                       input int a, input int b, input int d, input int off);
    exp_t e;
    start = st; base_addr = ba[7:0]; in_valid = v;
    in_opcode = op[2:0]; in_reg_a = a[2:0]; in_reg_b = b[2:0]; in_dest = d[2:0];
    in_offset = off;
    @(posedge clk);
    if (m_state != M_RUN) begin
      if (st) begin
        m_state = M_RUN; m_next = ba; m_cnt = 0;
        m_done = 0; m_erange = 0; m_efull = 0;
      end
    end else if (v) begin
      if (op >= 2 && op <= 4 && (off < -32768 || off > 32767)) begin
        m_erange = 1; m_state = M_ERR;
      end else if (m_next > 255) begin
        m_efull = 1; m_state = M_ERR;
      end else begin
        m_cnt++;
        e.addr = m_next; e.word = model_word(op, a, b, d, off); e.cnt = m_cnt;
        sb.push_back(e);
        m_next++;
        if (op == 6) begin m_state = M_DONE; m_done = 1; end
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) begin
        if (sb.size() == 0) check("unexpected_we", mem_we, 1'b0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("wr_addr",  mem_addr,   e.addr);
          check("wr_data",  mem_wdata,  e.word);
          check("wr_count", word_count, e.cnt);
        end
      end
      check("in_ready",   in_ready,   m_state == M_RUN);
      check("busy",       busy,       m_state == M_RUN);
      check("done",       done,       m_done);
      check("err_range",  err_range,  m_erange);
      check("err_full",   err_full,   m_efull);
      check("word_count", word_count, m_cnt);
    end
  end

  initial begin
    rst_n = 0; start = 0; base_addr = 0; in_valid = 0;
    in_opcode = 0; in_reg_a = 0; in_reg_b = 0; in_dest = 0; in_offset = 0;
    s_start = 0; s_base = 0; s_valid = 0; s_op = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_addr",   mem_addr, 0);
    check("rst_wdata",  mem_wdata, 0);
    check("rst_ready",  in_ready, 0);
    mon_en = 1;
    rst_n = 1;
    idle();

    // valid during IDLE is ignored; start with valid in the same cycle accepts nothing yet
    cycle(0, 0, 1, 0, 1, 2, 3, 0);
    cycle(1, 8'h10, 1, 7, 0, 0, 0, 0);
    check("t1_no_we_on_start", mem_we, 0);
    cycle(0, 0, 1, 0, 1, 2, 3, 99);
    check("t1_we",    mem_we, 1);
    check("t1_addr",  mem_addr, 8'h10);
    check("t1_data",  mem_wdata, 32'h000A0003);
    check("t1_count", word_count, 1);
    cycle(0, 0, 1, 6, 0, 0, 0, 0);
    idle();

    cycle(1, 8'h20, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 0, 1, 5, -1);
    check("t2_lw_addr", mem_addr, 8'h20);
    check("t2_lw_data", mem_wdata, 32'h0081FFFF);
    cycle(0, 0, 1, 3, 2, 3, 1, 5);
    check("t2_sw_addr", mem_addr, 8'h21);
    check("t2_sw_data", mem_wdata, 32'h00D30005);
    cycle(0, 0, 1, 6, 4, 4, 4, 77);
    check("t3_halt_data", mem_wdata, 32'h01800000);
    check("t3_done",      done, 1);
    check("t3_ready",     in_ready, 0);
    check("t3_count",     word_count, 3);
    cycle(1, 8'h99, 1, 0, 1, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 8'h30, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 1, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // restart from DONE keeps monitor aligned; the earlier start in DONE was already applied
    cycle(0, 0, 1, 6, 0, 0, 0, 0);

    cycle(1, 8'h40, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 4, 1, 1, 0, 32768);
    check("t4_no_we",   mem_we, 0);
    check("t4_erange",  err_range, 1);
    check("t4_busy",    busy, 0);
    cycle(1, 8'h41, 0, 0, 0, 0, 0, 0);
    check("t4_cleared", err_range, 0);
    cycle(0, 0, 1, 4, 7, 7, 0, -32769);
    cycle(1, 8'hFF, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 4, 1, 2, 0, -32768);
    check("t_top_addr", mem_addr, 8'hFF);
    cycle(0, 0, 1, 3, 1, 2, 0, 40000);
    check("t_range_over_full", err_range, 1);

    s_start = 1; s_base = 2'd2;
    @(posedge clk); #1;
    s_start = 0; s_valid = 1; s_op = 3'd7;
    @(posedge clk); #1;
    check("t5_we0",   s_we, 1);
    check("t5_addr0", s_addr, 2);
    check("t5_data0", s_wdata, 32'h01C00000);
    @(posedge clk); #1;
    check("t5_addr1", s_addr, 3);
    check("t5_cnt1",  s_count, 2);
    @(posedge clk); #1;
    check("t5_no_we", s_we, 0);
    check("t5_efull", s_efull, 1);
    check("t5_busy",  s_busy, 0);
    check("t5_cnt2",  s_count, 2);
    s_valid = 0;

    cycle(1, 8'h50, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 3, 4, 5, 0);
    cycle(0, 0, 1, 5, 3, 4, 5, 0);
    rst_n = 0;
    #1;
    check("t6_we",    mem_we, 0);
    check("t6_addr",  mem_addr, 0);
    check("t6_data",  mem_wdata, 0);
    check("t6_count", word_count, 0);
    check("t6_busy",  busy, 0);
    model_reset();
    @(posedge clk); #1;
    idle();
    rst_n = 1;
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 1, 1, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      bit st, v;
      int ba, op, off, sel;
      st  = (m_state != M_RUN) ? ($urandom % 4 == 0) : ($urandom % 16 == 0);
      ba  = ($urandom % 2) ? int'($urandom_range(248, 255)) : int'($urandom % 256);
      v   = ($urandom % 4 != 0);
      op  = $urandom % 8;
      sel = $urandom % 6;
      case (sel)
        0: off = int'($urandom_range(0, 65535)) - 32768;
        1: off = 32767;
        2: off = -32768;
        3: off = 32768;
        4: off = -32769;
        default: off = int'($urandom);
      endcase
      cycle(st, ba, v, op, $urandom % 8, $urandom % 8, $urandom % 8, off);
    end
    idle();
    idle();
    check("sb_empty", sb.size(), 0);
    mon_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
